// File: rtl/cpu32_pkg.sv
// Shared register-file constants and the one-hot write/issue decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu32_pkg;

    localparam int REG_COUNT  = 8;
    localparam int REG_ADDR_W = 3;
    localparam int DEF_WIDTH  = 16;

    // One-hot decode of a register address, all-zero when not enabled.
    function automatic logic [REG_COUNT-1:0] decoder8en(
        input logic                  en,
        input logic [REG_ADDR_W-1:0] addr
    );
        logic [REG_COUNT-1:0] onehot;
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/sb_scoreboard8.sv
// Pending-write scoreboard: one busy flop per register, issue sets, writeback clears.
// Latency: busy updates at the next clk edge; busy_a/busy_b are combinational lookups.
// Backpressure: none; busy_a/busy_b are the stall hints consumed by decode.
//
// Ports: clk, reset_n (async active-low), issue/issue_addr (set), we/waddr (clear),
//        raddr_a/raddr_b (lookup), busy_a/busy_b (operand not ready), busy (raw vector).
module sb_scoreboard8
    import cpu32_pkg::*;
#(
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic [REG_COUNT-1:0]  busy
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] set_vec;
    logic [REG_COUNT-1:0] clr_vec;
    logic [REG_COUNT-1:0] busy_nxt;
    logic                 fwd_a;
    logic                 fwd_b;

    // Set is applied after clear so a same-cycle issue (the younger write) wins.
    always_comb begin
        set_vec  = decoder8en(issue, issue_addr);
        clr_vec  = decoder8en(we, waddr);
        busy_nxt = set_vec | (busy_q & ~clr_vec);
        if (ZERO_R0 != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // A writeback being forwarded this cycle already satisfies the operand.
    assign fwd_a  = (BYPASS != 0) && we && (waddr == raddr_a);
    assign fwd_b  = (BYPASS != 0) && we && (waddr == raddr_b);
    assign busy_a = busy_q[raddr_a] & ~fwd_a;
    assign busy_b = busy_q[raddr_b] & ~fwd_b;
    assign busy   = busy_q;

endmodule

// File: rtl/regfile8_sb.sv
// 8-entry register file, two combinational read ports, one write port, pending-write scoreboard.
// Latency: reads 0 cycles (same-cycle forwarding when BYPASS=1); writes visible next cycle.
// Backpressure: none; busy_a/busy_b tell decode to stall on unavailable operands.
//
// Ports: clk, reset_n (async active-low), we/waddr/wdata (writeback), raddr_a/raddr_b ->
//        rdata_a/rdata_b (operand reads), issue/issue_addr (decode marks destination busy),
//        busy_a/busy_b (operand pending), busy (raw scoreboard).
module regfile8_sb
    import cpu32_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]      rdata_a,
    output logic [WIDTH-1:0]      rdata_b,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic [REG_COUNT-1:0]  busy
);

    logic [WIDTH-1:0]     regs [REG_COUNT];
    logic [REG_COUNT-1:0] wen;
    logic                 fwd_a;
    logic                 fwd_b;
    logic                 issue_ok;

    always_comb begin
        wen = decoder8en(we, waddr);
        if (ZERO_R0 != 0) begin
            wen[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (wen[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Forwarding is suppressed while reset is held so the read ports read zero then.
    assign fwd_a = (BYPASS != 0) && reset_n && we && (waddr == raddr_a);
    assign fwd_b = (BYPASS != 0) && reset_n && we && (waddr == raddr_b);

    // r0 override comes last so a forwarded write to r0 still reads as zero.
    always_comb begin
        rdata_a = fwd_a ? wdata : regs[raddr_a];
        if ((ZERO_R0 != 0) && (raddr_a == '0)) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = fwd_b ? wdata : regs[raddr_b];
        if ((ZERO_R0 != 0) && (raddr_b == '0)) begin
            rdata_b = '0;
        end
    end

    assign issue_ok = issue && !((ZERO_R0 != 0) && (issue_addr == '0));

    sb_scoreboard8 #(
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue      (issue_ok),
        .issue_addr (issue_addr),
        .we         (we),
        .waddr      (waddr),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .busy       (busy)
    );

endmodule

// File: tb/tb_regfile8_sb.sv
// Bench for regfile8_sb: two configurations (forwarding on / forwarding off + hard-zero r0)
// driven by the same stimulus, expected outputs queued per cycle and checked by a monitor.
// Stimulus: directed scenarios followed by random traffic with occasional mid-cycle resets.
module tb_regfile8_sb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [2:0]  raddr_a = '0;
    logic [2:0]  raddr_b = '0;
    logic        issue = 1'b0;
    logic [2:0]  issue_addr = '0;

    logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic        busy_a0, busy_b0, busy_a1, busy_b1;
    logic [7:0]  busy0, busy1;

    always #5 clk = ~clk;

    regfile8_sb #(.WIDTH(16), .BYPASS(1), .ZERO_R0(0)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
        .issue(issue), .issue_addr(issue_addr),
        .busy_a(busy_a0), .busy_b(busy_b0), .busy(busy0)
    );

    regfile8_sb #(.WIDTH(16), .BYPASS(0), .ZERO_R0(1)) dut_z (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
        .issue(issue), .issue_addr(issue_addr),
        .busy_a(busy_a1), .busy_b(busy_b1), .busy(busy1)
    );

    // Reference model: plain arrays per configuration.
    bit          cfg_byp [2] = '{1'b1, 1'b0};
    bit          cfg_zr  [2] = '{1'b0, 1'b1};
    logic [15:0] m_reg  [2][8];
    bit          m_busy [2][8];

    typedef struct {
        int          c;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        ba;
        logic        bb;
        logic [7:0]  bz;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] m_read(int c, logic [2:0] a, bit rst);
        if (cfg_zr[c] && a == 3'd0) return 16'h0;
        if (rst) return 16'h0;
        if (cfg_byp[c] && we && waddr == a) return wdata;
        return m_reg[c][a];
    endfunction

    function automatic logic m_busy_op(int c, logic [2:0] a);
        if (cfg_byp[c] && we && waddr == a) return 1'b0;
        return m_busy[c][a];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 8; r++) begin
                m_reg[c][r]  = 16'h0;
                m_busy[c][r] = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive at negedge, reset (if any) lands mid-cycle, expectation queued
    // before the rising edge, then the model advances as the edge would.
    task automatic step(input bit rst, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb,
                        input logic iss, input logic [2:0] ia);
        exp_t e;
        @(negedge clk);
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        issue = iss; issue_addr = ia;
        #1;
        reset_n = !rst;
        if (rst) model_reset();
        #1;
        for (int c = 0; c < 2; c++) begin
            e.c  = c;
            e.ra = m_read(c, ra, rst);
            e.rb = m_read(c, rb, rst);
            e.ba = rst ? 1'b0 : m_busy_op(c, ra);
            e.bb = rst ? 1'b0 : m_busy_op(c, rb);
            e.bz = '0;
            for (int r = 0; r < 8; r++) e.bz[r] = m_busy[c][r];
            exp_q.push_back(e);
        end
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                if (w && !(cfg_zr[c] && wa == 3'd0)) m_reg[c][wa] = wd;
                if (w) m_busy[c][wa] = 1'b0;
                if (iss && !(cfg_zr[c] && ia == 3'd0)) m_busy[c][ia] = 1'b1;
            end
        end
    endtask

    task automatic check16(input string name, input int c, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cfg%0d: got %h expected %h at %0t", name, c, act, req, $time);
        end
    endtask

    // Monitor: the outputs are valid every cycle, so drain whatever was queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.c == 0) begin
                    check16("rdata_a", 0, rdata_a0, e.ra);
                    check16("rdata_b", 0, rdata_b0, e.rb);
                    check16("busy_a", 0, {15'h0, busy_a0}, {15'h0, e.ba});
                    check16("busy_b", 0, {15'h0, busy_b0}, {15'h0, e.bb});
                    check16("busy", 0, {8'h0, busy0}, {8'h0, e.bz});
                end else begin
                    check16("rdata_a", 1, rdata_a1, e.ra);
                    check16("rdata_b", 1, rdata_b1, e.rb);
                    check16("busy_a", 1, {15'h0, busy_a1}, {15'h0, e.ba});
                    check16("busy_b", 1, {15'h0, busy_b1}, {15'h0, e.bb});
                    check16("busy", 1, {8'h0, busy1}, {8'h0, e.bz});
                end
            end
        end
    end

    initial begin
        model_reset();
        // Reset, then load r3 and hit it with a mid-cycle reset that also carries a write+issue.
        step(1, 0, 3'd0, 16'h0000, 3'd0, 3'd0, 0, 3'd0);
        step(0, 1, 3'd3, 16'h1234, 3'd3, 3'd0, 0, 3'd0);
        step(0, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 1, 3'd6);
        step(1, 1, 3'd3, 16'h5555, 3'd3, 3'd6, 1, 3'd3);
        step(0, 0, 3'd0, 16'h0000, 3'd3, 3'd6, 0, 3'd0);
        // Write r5 and read it in the write cycle and the following one.
        step(0, 1, 3'd5, 16'hBEEF, 3'd5, 3'd1, 0, 3'd0);
        step(0, 0, 3'd0, 16'h0000, 3'd5, 3'd5, 0, 3'd0);
        // Issue r2, watch busy, forwarded writeback clears it.
        step(0, 0, 3'd0, 16'h0000, 3'd0, 3'd2, 1, 3'd2);
        step(0, 0, 3'd0, 16'h0000, 3'd0, 3'd2, 0, 3'd0);
        step(0, 1, 3'd2, 16'h0BAD, 3'd0, 3'd2, 0, 3'd0);
        step(0, 0, 3'd0, 16'h0000, 3'd2, 3'd2, 0, 3'd0);
        // Issue and writeback to r4 together: busy stays set, data lands.
        step(0, 1, 3'd4, 16'h0042, 3'd1, 3'd4, 1, 3'd4);
        step(0, 0, 3'd0, 16'h0000, 3'd4, 3'd4, 0, 3'd0);
        // Both ports on r7 while it is written (and pending).
        step(0, 0, 3'd0, 16'h0000, 3'd7, 3'd7, 1, 3'd7);
        step(0, 1, 3'd7, 16'hA5A5, 3'd7, 3'd7, 0, 3'd0);
        step(0, 0, 3'd0, 16'h0000, 3'd7, 3'd7, 0, 3'd0);
        // r0 write + issue, then read it back.
        step(0, 1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1, 3'd0);
        step(0, 0, 3'd0, 16'h0000, 3'd0, 3'd0, 0, 3'd0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        @(negedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
